// File: rtl/pcim_cmd_gen.sv
// pcim_cmd_gen: upstream command generator for the PCIM DMA controller.
// One bulk descriptor (direction, channel, FPGA base page, first PCIe-address
// slot, page count) is written over SoftRegs and split into 64-bit PCIM_CMD
// words of at most MAX_CMD_PAGES 4 KiB pages, one address slot per word.
// Issue is throttled by an outstanding-page budget and an outstanding-command
// budget, so the non-backpressured command FIFO downstream cannot overflow.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cfg_*             SoftReg write/read request, read response one cycle later
//   cmd_valid/ready   PCIM_CMD handshake, cmd_data registered and held
//   page_done         one pulse per completed 4 KiB write burst
//   busy              transfer in progress (state != IDLE)
module pcim_cmd_gen #(
  parameter int MAX_CMD_PAGES = 16,
  parameter int MAX_OUT_PAGES = 64,
  parameter int MAX_OUT_CMDS  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  input  logic        cfg_write,
  input  logic [31:0] cfg_addr,
  input  logic [63:0] cfg_data,
  output logic        cfg_resp_valid,
  output logic [63:0] cfg_resp_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [63:0] cmd_data,
  input  logic        page_done,
  output logic        busy
);

  localparam int CW  = $clog2(MAX_CMD_PAGES) + 1;
  // Size FIFO pointers wrap naturally; MAX_OUT_CMDS is a power of two.
  localparam int FPW = (MAX_OUT_CMDS > 1) ? $clog2(MAX_OUT_CMDS) : 1;
  localparam int OCW = $clog2(MAX_OUT_CMDS + 1);
  localparam int OPW = $clog2(MAX_OUT_PAGES + MAX_CMD_PAGES + 1);
  localparam logic [19:0] MAX_CHUNK_L = 20'(MAX_CMD_PAGES);
  localparam logic [31:0] MAX_OUT_PAGES_L = 32'(MAX_OUT_PAGES);
  localparam logic [31:0] MAX_OUT_CMDS_L  = 32'(MAX_OUT_CMDS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [23:0]     base_page_q, base_page_d;
  logic [5:0]      sel_cfg_q, sel_cfg_d;
  logic [1:0]      chan_cfg_q, chan_cfg_d;
  logic            rd_cfg_q, rd_cfg_d;
  logic [23:0]     page_q, page_d;
  logic [5:0]      sel_q, sel_d;
  logic [1:0]      chan_q, chan_d;
  logic            rd_q, rd_d;
  logic [19:0]     remaining_q, remaining_d;
  logic [OPW-1:0]  out_pages_q, out_pages_d;
  logic [OCW-1:0]  out_cmds_q, out_cmds_d;
  logic [31:0]     completed_q, completed_d;
  logic [CW-1:0]   head_cnt_q, head_cnt_d;
  logic [FPW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            done_q, done_d, error_q, error_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [63:0]     cmd_data_q, cmd_data_d;
  logic            resp_valid_q, resp_valid_d;
  logic [63:0]     resp_data_q, resp_data_d;
  logic [CW-1:0]   size_fifo_q [MAX_OUT_CMDS];

  logic            cfg_wr_s, launch_s, hs_s, pd_ok_s, retire_s, busy_s;
  logic [19:0]     launch_cnt_s;
  logic [CW-1:0]   chunk_s, chunk_n_s, head_size_s;
  logic [31:0]     need_s;
  logic            unused_s;

  assign cfg_wr_s     = cfg_valid && cfg_write;
  assign launch_s     = cfg_wr_s && (cfg_addr == 32'h0000_0010);
  assign launch_cnt_s = cfg_data[19:0];
  assign hs_s         = cmd_valid_q && cmd_ready;
  assign busy_s       = (state_q != S_IDLE);
  // Size of the command currently on the port (remaining does not move while it waits).
  assign chunk_s      = (remaining_q < MAX_CHUNK_L) ? remaining_q[CW-1:0] : CW'(MAX_CMD_PAGES);
  assign pd_ok_s      = page_done && (out_pages_q != {OPW{1'b0}});
  assign head_size_s  = size_fifo_q[rd_ptr_q];
  assign retire_s     = pd_ok_s && ((head_cnt_q + CW'(1)) == head_size_s);
  assign unused_s     = ^cfg_data[63:24];

  // Next-state, accounting, command word and read response.
  always_comb begin
    state_d      = state_q;
    base_page_d  = base_page_q;
    sel_cfg_d    = sel_cfg_q;
    chan_cfg_d   = chan_cfg_q;
    rd_cfg_d     = rd_cfg_q;
    page_d       = page_q;
    sel_d        = sel_q;
    chan_d       = chan_q;
    rd_d         = rd_q;
    remaining_d  = remaining_q;
    completed_d  = completed_q;
    head_cnt_d   = head_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    done_d       = done_q;
    error_d      = error_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_data_d   = cmd_data_q;
    chunk_n_s    = {CW{1'b0}};
    need_s       = 32'd0;

    if (cfg_wr_s && (cfg_addr == 32'h0000_0000)) begin
      base_page_d = cfg_data[23:0];
    end else if (cfg_wr_s && (cfg_addr == 32'h0000_0008)) begin
      sel_cfg_d  = cfg_data[5:0];
      chan_cfg_d = cfg_data[7:6];
      rd_cfg_d   = cfg_data[8];
    end else begin
      base_page_d = base_page_q;
    end

    case (state_q)
      S_IDLE: begin
        if (launch_s) begin
          error_d     = 1'b0;
          completed_d = 32'd0;
          if (launch_cnt_s == 20'd0) begin
            done_d = 1'b1;
          end else begin
            done_d      = 1'b0;
            remaining_d = launch_cnt_s;
            page_d      = base_page_q;
            sel_d       = sel_cfg_q;
            chan_d      = chan_cfg_q;
            rd_d        = rd_cfg_q;
            state_d     = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        error_d = error_q | launch_s;
        if (hs_s) begin
          remaining_d = remaining_q - 20'(chunk_s);
          page_d      = page_q + 24'(chunk_s);
          sel_d       = sel_q + 6'd1;
          state_d     = (remaining_q == 20'(chunk_s)) ? S_DRAIN : S_ISSUE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        error_d = error_q | launch_s;
        if (out_pages_q == {OPW{1'b0}}) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake and completion on the same cycle both apply.
    out_pages_d = out_pages_q + (hs_s ? OPW'(chunk_s) : {OPW{1'b0}})
                              - (pd_ok_s ? OPW'(1) : {OPW{1'b0}});
    case ({hs_s, retire_s})
      2'b10:   out_cmds_d = out_cmds_q + OCW'(1);
      2'b01:   out_cmds_d = out_cmds_q - OCW'(1);
      default: out_cmds_d = out_cmds_q;
    endcase
    wr_ptr_d = hs_s ? (wr_ptr_q + FPW'(1)) : wr_ptr_q;

    if (pd_ok_s) begin
      completed_d = completed_q + 32'd1;
      if (retire_s) begin
        head_cnt_d = {CW{1'b0}};
        rd_ptr_d   = rd_ptr_q + FPW'(1);
      end else begin
        head_cnt_d = head_cnt_q + CW'(1);
      end
    end else if (page_done) begin
      error_d = 1'b1;
    end else begin
      head_cnt_d = head_cnt_q;
    end

    // The next word is built from post-edge values, so cmd_valid never waits on cmd_ready.
    if (cmd_valid_q && !cmd_ready) begin
      cmd_valid_d = 1'b1;
      cmd_data_d  = cmd_data_q;
    end else begin
      chunk_n_s   = (remaining_d < MAX_CHUNK_L) ? remaining_d[CW-1:0] : CW'(MAX_CMD_PAGES);
      need_s      = 32'(out_pages_d) + 32'(chunk_n_s);
      cmd_valid_d = (state_d == S_ISSUE) && (remaining_d != 20'd0) &&
                    (need_s <= MAX_OUT_PAGES_L) && (32'(out_cmds_d) < MAX_OUT_CMDS_L);
      cmd_data_d  = cmd_valid_d ? {rd_d, chan_d, 16'({chunk_n_s, 6'b0}) - 16'd1,
                                   sel_d, page_d, 15'd0} : 64'd0;
    end

    resp_valid_d = cfg_valid && !cfg_write;
    if (resp_valid_d) begin
      resp_data_d = {completed_q, remaining_q, 9'd0, error_q, done_q, busy_s};
    end else begin
      resp_data_d = resp_data_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_page_q  <= 24'd0;
      sel_cfg_q    <= 6'd0;
      chan_cfg_q   <= 2'd0;
      rd_cfg_q     <= 1'b0;
      page_q       <= 24'd0;
      sel_q        <= 6'd0;
      chan_q       <= 2'd0;
      rd_q         <= 1'b0;
      remaining_q  <= 20'd0;
      out_pages_q  <= {OPW{1'b0}};
      out_cmds_q   <= {OCW{1'b0}};
      completed_q  <= 32'd0;
      head_cnt_q   <= {CW{1'b0}};
      wr_ptr_q     <= {FPW{1'b0}};
      rd_ptr_q     <= {FPW{1'b0}};
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_data_q   <= 64'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 64'd0;
    end else begin
      state_q      <= state_d;
      base_page_q  <= base_page_d;
      sel_cfg_q    <= sel_cfg_d;
      chan_cfg_q   <= chan_cfg_d;
      rd_cfg_q     <= rd_cfg_d;
      page_q       <= page_d;
      sel_q        <= sel_d;
      chan_q       <= chan_d;
      rd_q         <= rd_d;
      remaining_q  <= remaining_d;
      out_pages_q  <= out_pages_d;
      out_cmds_q   <= out_cmds_d;
      completed_q  <= completed_d;
      head_cnt_q   <= head_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_data_q   <= cmd_data_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Page counts of issued commands, oldest at rd_ptr.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUT_CMDS; i++) begin
        size_fifo_q[i] <= {CW{1'b0}};
      end
    end else if (hs_s) begin
      size_fifo_q[wr_ptr_q] <= chunk_s;
    end
  end

  assign cmd_valid      = cmd_valid_q;
  assign cmd_data       = cmd_data_q;
  assign cfg_resp_valid = resp_valid_q;
  assign cfg_resp_data  = resp_data_q;
  assign busy           = busy_s;

endmodule

// File: tb/tb_pcim_cmd_gen.sv
// Randomized bench for pcim_cmd_gen against a transaction-level model: each
// launch is expanded into its expected command list, outstanding pages and
// command sizes are tracked in plain integers and a queue.
module tb_pcim_cmd_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cfg_valid, cfg_write, cfg_resp_valid, cmd_valid, cmd_ready, page_done, busy;
  logic [31:0] cfg_addr;
  logic [63:0] cfg_data, cfg_resp_data, cmd_data;

  pcim_cmd_gen dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_write(cfg_write),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_resp_valid(cfg_resp_valid),
    .cfg_resp_data(cfg_resp_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .page_done(page_done), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Model state
  logic [23:0] m_base;
  logic [5:0]  m_sel;
  logic [1:0]  m_ch;
  logic        m_rd;
  logic [63:0] m_exp[$];
  int          m_sizes[$];
  int m_head, m_rem, m_out, m_completed, hs_count, stall;
  bit m_busy, m_done, m_error;

  function automatic int chunk_of(input int r);
    return (r < 16) ? r : 16;
  endfunction

  function automatic bit credit_ok();
    return ((m_out + chunk_of(m_rem)) <= 64) && (m_sizes.size() < 32);
  endfunction

  function automatic void model_reset();
    m_exp.delete();
    m_sizes.delete();
    m_base = 24'd0; m_sel = 6'd0; m_ch = 2'd0; m_rd = 1'b0;
    m_head = 0; m_rem = 0; m_out = 0; m_completed = 0; stall = 0;
    m_busy = 1'b0; m_done = 1'b0; m_error = 1'b0;
  endfunction

  function automatic void build_cmds(input int n);
    logic [23:0] pg;
    logic [5:0]  sl;
    int left, c;
    pg = m_base; sl = m_sel; left = n;
    while (left > 0) begin
      c = chunk_of(left);
      m_exp.push_back({m_rd, m_ch, 16'(c * 64 - 1), sl, pg, 15'd0});
      pg = pg + 24'(c);
      sl = sl + 6'd1;
      left -= c;
    end
  endfunction

  // One clock: inputs already driven; sample pre-edge, update model, check post-edge.
  task automatic tick();
    bit hs_p, pd_p, vhold, wr_p, rd_p, rst_p;
    logic [31:0] a_p;
    logic [63:0] wd_p, d_p, resp_exp;
    int c;
    hs_p = (cmd_valid === 1'b1) && (cmd_ready === 1'b1);
    vhold = (cmd_valid === 1'b1) && (cmd_ready === 1'b0);
    d_p = cmd_data; pd_p = page_done; rst_p = rst;
    wr_p = cfg_valid && cfg_write; rd_p = cfg_valid && !cfg_write;
    a_p = cfg_addr; wd_p = cfg_data;
    resp_exp = {32'(m_completed), 20'(m_rem), 9'd0, m_error, m_done, m_busy};
    @(posedge clk);
    #1;
    if (rst_p) begin
      model_reset();
      check("rst_valid", 64'(cmd_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      return;
    end
    if (wr_p) begin
      if (a_p == 32'h0) m_base = wd_p[23:0];
      else if (a_p == 32'h8) begin
        m_sel = wd_p[5:0]; m_ch = wd_p[7:6]; m_rd = wd_p[8];
      end else if (a_p == 32'h10) begin
        if (m_busy) m_error = 1'b1;
        else begin
          m_error = 1'b0; m_completed = 0;
          if (wd_p[19:0] == 20'd0) m_done = 1'b1;
          else begin
            m_done = 1'b0; m_busy = 1'b1; m_rem = int'(wd_p[19:0]);
            build_cmds(m_rem);
          end
        end
      end
    end
    if (pd_p) begin
      if (m_out == 0) m_error = 1'b1;
      else begin
        m_out--; m_completed++; m_head++;
        if (m_head == m_sizes[0]) begin
          void'(m_sizes.pop_front());
          m_head = 0;
        end
      end
    end
    if (hs_p) begin
      hs_count++;
      if (m_exp.size() == 0) check("cmd_extra", 64'(m_exp.size()), 64'd1);
      else begin
        check("cmd_word", d_p, m_exp.pop_front());
        c = chunk_of(m_rem);
        m_rem -= c; m_out += c; m_sizes.push_back(c);
      end
    end
    check("resp_valid", 64'(cfg_resp_valid), 64'(rd_p));
    if (rd_p) check("resp_data", cfg_resp_data, resp_exp);
    if (vhold) begin
      check("hold_valid", 64'(cmd_valid), 64'd1);
      check("hold_data", cmd_data, d_p);
    end
    if (cmd_valid === 1'b1) begin
      check("issue_allowed", 64'(credit_ok() && (m_exp.size() > 0)), 64'd1);
      if (m_exp.size() > 0) check("cmd_head", cmd_data, m_exp[0]);
    end
    if (m_rem > 0) check("busy_active", 64'(busy), 64'd1);
    if ((cmd_valid !== 1'b1) && (m_rem > 0) && credit_ok()) stall++;
    else stall = 0;
    if (stall == 3) check("issue_stall", 64'(cmd_valid), 64'd1);
  endtask

  task automatic cfg_wr(input logic [31:0] a, input logic [63:0] d);
    cfg_valid = 1'b1; cfg_write = 1'b1; cfg_addr = a; cfg_data = d; page_done = 1'b0;
    tick();
    cfg_valid = 1'b0; cfg_write = 1'b0;
  endtask

  task automatic cfg_rd();
    cfg_valid = 1'b1; cfg_write = 1'b0; cfg_addr = 32'h18; page_done = 1'b0;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic launch(input logic [23:0] b, input logic [5:0] s, input logic [1:0] ch,
                        input logic rd, input int n);
    cfg_wr(32'h0, {40'd0, b});
    cfg_wr(32'h8, {55'd0, rd, ch, s});
    cfg_wr(32'h10, 64'(n));
  endtask

  // Run random ready/page_done until the model drains, then expect busy to drop.
  task automatic wait_idle(input bit rdy_always);
    int t;
    t = 0;
    while (((m_rem > 0) || (m_out > 0)) && (t < 3000)) begin
      cmd_ready = rdy_always ? 1'b1 : ($urandom_range(0, 3) != 0);
      page_done = (m_out > 0) && ($urandom_range(0, 1) == 1);
      tick();
      t++;
    end
    page_done = 1'b0;
    if ((m_rem > 0) || (m_out > 0)) check("drain_left", 64'(m_rem + m_out), 64'd0);
    t = 0;
    while ((busy === 1'b1) && (t < 5)) begin
      tick();
      t++;
    end
    check("idle_busy", 64'(busy), 64'd0);
    if (m_busy) begin
      m_busy = 1'b0;
      m_done = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_write = 1'b0; cfg_addr = 32'd0; cfg_data = 64'd0;
    cmd_ready = 1'b0; page_done = 1'b0; hs_count = 0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    check("reset_cmd_valid", 64'(cmd_valid), 64'd0);
    check("reset_cmd_data", cmd_data, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_resp_valid", 64'(cfg_resp_valid), 64'd0);
    check("reset_resp_data", cfg_resp_data, 64'd0);
    cfg_rd();

    // Basic split: 40 pages -> 16/16/8
    cmd_ready = 1'b1; hs_count = 0;
    launch(24'h000100, 6'd5, 2'd2, 1'b1, 40);
    wait_idle(1'b1);
    check("split_cmds", 64'(hs_count), 64'd3);
    cfg_rd();

    // Zero-length launch
    hs_count = 0;
    cfg_wr(32'h10, 64'd0);
    check("zero_valid", 64'(cmd_valid), 64'd0);
    check("zero_busy", 64'(busy), 64'd0);
    cfg_rd();
    check("zero_cmds", 64'(hs_count), 64'd0);

    // Credit throttle
    cmd_ready = 1'b1; hs_count = 0;
    launch(24'h000200, 6'd0, 2'd1, 1'b0, 200);
    repeat (20) tick();
    check("thr_cmds", 64'(hs_count), 64'd4);
    check("thr_valid", 64'(cmd_valid), 64'd0);
    page_done = 1'b1; tick(); page_done = 1'b0;
    repeat (5) tick();
    check("thr_one_pd", 64'(hs_count), 64'd4);
    page_done = 1'b1;
    repeat (15) tick();
    page_done = 1'b0;
    repeat (5) tick();
    check("thr_release", 64'(hs_count), 64'd5);
    wait_idle(1'b0);
    cfg_rd();

    // Backpressure
    cmd_ready = 1'b0;
    launch(24'h000300, 6'd10, 2'd3, 1'b1, 32);
    hs_count = 0;
    repeat (10) tick();
    check("bp_none", 64'(hs_count), 64'd0);
    check("bp_valid", 64'(cmd_valid), 64'd1);
    cmd_ready = 1'b1; tick();
    cmd_ready = 1'b0; tick();
    check("bp_one", 64'(hs_count), 64'd1);
    wait_idle(1'b0);

    // Wrap, busy launch, spurious page_done
    cmd_ready = 1'b0;
    launch(24'hFFFFF8, 6'd63, 2'd1, 1'b0, 32);
    cfg_wr(32'h10, 64'd5);
    cfg_rd();
    wait_idle(1'b0);
    cfg_rd();
    cfg_wr(32'h10, 64'd0);
    page_done = 1'b1; tick(); page_done = 1'b0;
    cfg_rd();

    // Random transfers
    for (int i = 0; i < 6; i++) begin
      launch(24'($urandom), 6'($urandom), 2'($urandom), 1'($urandom), $urandom_range(1, 120));
      wait_idle(1'b0);
      cfg_rd();
    end

    // Reset mid-transfer
    cmd_ready = 1'b0;
    launch(24'h000400, 6'd2, 2'd0, 1'b1, 100);
    tick();
    check("pre_rst_valid", 64'(cmd_valid), 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    cfg_rd();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pcim_cmd_gen.md
Name: pcim_cmd_gen

Overview:
- Upstream command generator for the PCIM DMA controller.
- Accepts one bulk transfer descriptor from host SoftRegs: direction, channel, FPGA base page, first PCIe-address-RAM slot, page count.
- Splits the transfer into 64-bit PCIM_CMD words of at most MAX_CMD_PAGES 4 KiB pages each, using one address-RAM slot per command.
- Throttles issue against the DMA controller's 32-entry command FIFO and against per-page write completions, so the controller's non-backpressured command port never overflows.

Parameters:
- MAX_CMD_PAGES, 16, maximum 4 KiB pages per emitted command (power of 2, 1..1024).
- MAX_OUT_PAGES, 64, maximum pages issued but not yet completed.
- MAX_OUT_CMDS, 32, maximum commands issued but not yet fully completed; matches the downstream FIFO depth.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_valid  in  1  SoftReg request strobe.
- cfg_write  in  1  1 = write, 0 = read.
- cfg_addr  in  32  byte address.
- cfg_data  in  64  write data.
- cfg_resp_valid  out  1  read response strobe.
- cfg_resp_data  out  64  read response data.
- cmd_valid  out  1  PCIM_CMD word valid.
- cmd_ready  in  1  downstream accepts the word; transfer occurs when cmd_valid && cmd_ready.
- cmd_data  out  64  PCIM_CMD word, packed as below.
- page_done  in  1  one-cycle pulse per completed 64-beat (4 KiB) write burst from the DMA controller.
- busy  out  1  transfer in progress.

Behaviour:
- PCIM_CMD packing:
  - [63] fpga_read
  - [62:61] channel
  - [60:45] count = pages*64-1
  - [44:39] pcie_sel
  - [38:15] fpga_page
  - [14:0] = 0
- Config writes:
  - 0x00: FPGA base page = data[23:0].
  - 0x08: data[5:0] = first pcie_sel; data[7:6] = channel; data[8] = fpga_read.
  - 0x10: launch with total page count = data[19:0].
  - Other addresses are ignored.
- Config read, any address: cfg_resp_valid is asserted the next cycle with:
  - [63:32] pages completed
  - [31:12] pages remaining to issue
  - [2] error
  - [1] done
  - [0] busy
- Reset values:
  - cmd_valid = 0, cmd_data = 0.
  - busy = 0.
  - cfg_resp_valid = 0, cfg_resp_data = 0.
  - All counters and flags = 0; state = IDLE.
- States:
  - IDLE:
    - Launch with count 0: done set, stays IDLE.
    - Launch with count > 0: latch the descriptor, clear done, go to ISSUE.
  - ISSUE:
    - chunk = min(remaining, MAX_CMD_PAGES).
    - cmd_valid = 1 only when out_pages + chunk <= MAX_OUT_PAGES and out_cmds < MAX_OUT_CMDS.
    - cmd_data is registered and stable while cmd_valid && !cmd_ready.
    - On each handshake:
      - remaining -= chunk; fpga_page += chunk (24-bit wrap); pcie_sel += 1 (6-bit wrap, 63 -> 0).
      - out_pages += chunk; out_cmds += 1.
    - When remaining reaches 0, go to DRAIN.
  - DRAIN: when out_pages == 0, set done and return to IDLE.
- Completion accounting:
  - Each page_done decrements out_pages and increments pages completed.
  - A per-command page counter tracks completions; out_cmds decrements when the oldest command's pages are all complete. Oldest-command sizes are held in a MAX_OUT_CMDS-deep size FIFO.
  - page_done on the same cycle as a handshake: both updates apply; net out_pages = out_pages + chunk - 1.
  - page_done with out_pages == 0: ignored and error set (sticky until reset or the next launch).
- Launch while busy: ignored and error set; the in-flight transfer is unaffected.
- busy = (state != IDLE).
- Reset mid-transfer: returns to IDLE immediately and drops cmd_valid. Downstream in-flight work is not tracked after reset.
- cmd_valid never depends combinationally on cmd_ready.

Test Plan:
- Basic split:
  - Stimulus: base page 0x000100, sel 5, channel 2, fpga_read 1, launch 40; cmd_ready = 1; 40 page_done pulses.
  - Required: 3 commands with (count, sel, page) = (1023, 5, 0x100), (1023, 6, 0x110), (511, 7, 0x120); done = 1, completed = 40.
- Zero-length launch:
  - Stimulus: launch 0.
  - Required: no cmd_valid; done = 1 the next cycle; busy stays 0.
- Credit throttle:
  - Stimulus: launch 200, no page_done.
  - Required: exactly 4 commands issued (64 pages), then cmd_valid = 0; one page_done does not release issue; 16 page_done pulses release exactly one more command.
- Backpressure:
  - Stimulus: cmd_ready held 0 for 10 cycles.
  - Required: cmd_data stable and cmd_valid held for all 10 cycles; exactly one handshake on release.
- Wrap and errors:
  - Stimulus: sel 63 with base page 0xFFFFF8 and 32 pages; then a launch while busy; then a spurious page_done when idle.
  - Required: second command has sel 0 and page 0x000008; busy-launch ignored with error = 1; spurious page_done sets error.
- Reset mid-transfer:
  - Stimulus: rst asserted during ISSUE with cmd_valid = 1.
  - Required: next cycle cmd_valid = 0, busy = 0, all counters 0.
